// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO pointer bundle: producer request and synchronized read
// pointer in, memory address / Gray pointer / status flags out.
interface wptr_full_ctrl_if #(
  parameter int unsigned addr_size = 3
);
  logic                 winc;
  logic [addr_size:0]   wq2_rptr;
  logic [addr_size-1:0] waddr;
  logic [addr_size:0]   wptr;
  logic                 wfull;
  logic                 walmost_full;
  logic [addr_size:0]   wlevel;

  // Producer / environment side
  modport master (
    output winc, wq2_rptr,
    input  waddr, wptr, wfull, walmost_full, wlevel
  );

  // Controller side
  modport slave (
    input  winc, wq2_rptr,
    output waddr, wptr, wfull, walmost_full, wlevel
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full-flag controller for the asynchronous FIFO.
// Holds binary/Gray write pointers and derives full, almost-full and fill
// level against the read pointer already synchronized into wclk.

// Kogge-Stone prefix adder. Only the carries into bits 1..data_size-1 are
// built; the carry-out of the top bit is never needed, so sums wrap.
module ksa_adder #(
  parameter int unsigned data_size = 4
) (
  input  logic [data_size-1:0] a,
  input  logic [data_size-1:0] b,
  input  logic                 cin,
  output logic [data_size-1:0] sum
);
  localparam int unsigned CW  = data_size - 1;
  localparam int unsigned LVL = $clog2(CW);

  logic [data_size-1:0] p_bit;
  logic [CW-1:0]        carry;

  assign p_bit = a ^ b;

  // Parallel-prefix generate/propagate tree; cin folds into bit 0 generate
  always_comb begin
    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [CW-1:0] g_n;
    logic [CW-1:0] p_n;
    g    = a[CW-1:0] & b[CW-1:0];
    g[0] = g[0] | (p_bit[0] & cin);
    p    = p_bit[CW-1:0];
    for (int k = 0; k < int'(LVL); k++) begin
      g_n = g;
      p_n = p;
      for (int i = 0; i < int'(CW); i++) begin
        if (i >= (1 << k)) begin
          g_n[i] = g[i] | (p[i] & g[i - (1 << k)]);
          p_n[i] = p[i] & p[i - (1 << k)];
        end
      end
      g = g_n;
      p = p_n;
    end
    carry = g;
  end

  assign sum = p_bit ^ {carry, cin};
endmodule

module wptr_full_ctrl #(
  parameter int unsigned addr_size = 3,
  parameter int unsigned af_margin = 1
) (
  input  logic              wclk,
  input  logic              wrst_n,
  wptr_full_ctrl_if.slave   bus
);
  localparam int unsigned PW    = addr_size + 1;
  localparam int unsigned DEPTH = 32'd1 << addr_size;
  // Gray pointers one lap apart differ in exactly their top two bits
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] AF_LEVEL  = PW'(DEPTH - af_margin);

  logic [PW-1:0] wbin_q,   wbin_d;
  logic [PW-1:0] wptr_q,   wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q,  wfull_d;
  logic          waf_q,    waf_d;
  logic [PW-1:0] rbin;
  logic          winc_ok;

  // Requests arriving while full are dropped
  assign winc_ok = bus.winc & ~wfull_q;

  ksa_adder #(.data_size(PW)) u_inc (
    .a   (wbin_q),
    .b   (PW'(0)),
    .cin (winc_ok),
    .sum (wbin_d)
  );

  // Gray-to-binary of the synchronized read pointer
  always_comb begin
    rbin         = '0;
    rbin[PW-1]   = bus.wq2_rptr[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ bus.wq2_rptr[i];
    end
  end

  // Next Gray pointer, occupancy and flags
  always_comb begin
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    wlevel_d = wbin_d - rbin;
    wfull_d  = (wptr_d == (bus.wq2_rptr ^ FULL_MASK));
    waf_d    = (wlevel_d >= AF_LEVEL);
  end

  // Pointer and status registers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
    end
  end

  assign bus.waddr        = wbin_q[addr_size-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = waf_q;
  assign bus.wlevel       = wlevel_q;
endmodule
